// File: rtl/riscv_i32c_fetch_align_if.sv
// Bus bundle between the fetch aligner, the instruction memory port and the decode stage.
//
//   master : the fetch aligner (drives fetch requests and the instruction output)
//   slave  : the environment (memory port plus decode-stage consumer)
//
// Signals:
//   fetch_req_valid / fetch_req_address / fetch_req_ready   word-aligned fetch request
//   fetch_resp_valid / fetch_resp_data                      read data, little-endian
//   instruction_valid / instruction_ready                   instruction handshake
//   instruction__mode / instruction__data / instruction_pc  presented instruction
//   fetch_resp_error / instruction_fault                    only with RISCV_FETCH_ALIGN_FAULT_EN
interface riscv_i32c_fetch_align_if;
   logic        fetch_req_valid;
   logic [31:0] fetch_req_address;
   logic        fetch_req_ready;
   logic        fetch_resp_valid;
   logic [31:0] fetch_resp_data;
   logic        instruction_valid;
   logic        instruction_ready;
   logic [2:0]  instruction__mode;
   logic [31:0] instruction__data;
   logic [31:0] instruction_pc;
`ifdef RISCV_FETCH_ALIGN_FAULT_EN
   logic        fetch_resp_error;
   logic        instruction_fault;

   modport master (
      output fetch_req_valid, fetch_req_address,
      input  fetch_req_ready, fetch_resp_valid, fetch_resp_data, fetch_resp_error,
      output instruction_valid, instruction__mode, instruction__data, instruction_pc,
      output instruction_fault,
      input  instruction_ready
   );

   modport slave (
      input  fetch_req_valid, fetch_req_address,
      output fetch_req_ready, fetch_resp_valid, fetch_resp_data, fetch_resp_error,
      input  instruction_valid, instruction__mode, instruction__data, instruction_pc,
      input  instruction_fault,
      output instruction_ready
   );
`else
   modport master (
      output fetch_req_valid, fetch_req_address,
      input  fetch_req_ready, fetch_resp_valid, fetch_resp_data,
      output instruction_valid, instruction__mode, instruction__data, instruction_pc,
      input  instruction_ready
   );

   modport slave (
      input  fetch_req_valid, fetch_req_address,
      output fetch_req_ready, fetch_resp_valid, fetch_resp_data,
      input  instruction_valid, instruction__mode, instruction__data, instruction_pc,
      output instruction_ready
   );
`endif
endinterface

// File: rtl/riscv_i32c_fetch_align.sv
// Instruction fetch aligner: issues word-aligned fetches, buffers returned words as halfwords
// and presents one aligned instruction (16-bit compressed or 32-bit, possibly straddling a
// word boundary) per handshake to the decode stage.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   riscv_config__i32c  compressed instructions enabled
//   mode                current privilege mode, forwarded to instruction__mode
//   redirect_valid/pc   flush buffer and restart fetching at redirect_pc (bit0 ignored)
//   bus (master)        fetch request/response and instruction output bundle
//
// Optional feature macro: RISCV_FETCH_ALIGN_FAULT_EN adds fetch_resp_error / instruction_fault
// on the bus; each buffered halfword then carries the error bit of its response.
module riscv_i32c_fetch_align #(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             riscv_config__i32c,
   input  logic [2:0]                       mode,
   input  logic                             redirect_valid,
   input  logic [31:0]                      redirect_pc,
   riscv_i32c_fetch_align_if.master         bus
);

   // h0 in [15:0], h1 in [31:16], h2 in [47:32]
   logic [47:0] hbuf_q, hbuf_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] head_pc_q, head_pc_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        outstanding_q, outstanding_d;
   logic        discard_q, discard_d;
   logic        skip_low_q, skip_low_d;

   logic        head_fault;
   logic        is_comp, one_half, inst_valid;
   logic        fire, resp, consume, skip_eff;
   logic [1:0]  shamt, cnt_s, app_n;
   logic [47:0] sh_vec, keep_vec, ext_vec;
   logic [31:0] app_vec;
   logic [15:0] h0, h1;

   assign h0 = hbuf_q[15:0];
   assign h1 = hbuf_q[31:16];

   // A faulted head is always presented as a one-halfword 32-bit item so it never stalls.
   assign is_comp    = riscv_config__i32c && (h0[1:0] != 2'b11) && !head_fault;
   assign one_half   = is_comp || head_fault;
   assign inst_valid = one_half ? (count_q != 2'd0) : (count_q >= 2'd2);

   assign fire    = bus.fetch_req_valid && bus.fetch_req_ready;
   assign resp    = bus.fetch_resp_valid && outstanding_q;
   assign consume = inst_valid && bus.instruction_ready;
   // Reset value of skip_low is RESET_PC[1]; qualifying with i32c here gives the
   // configuration-dependent behaviour without an input-dependent async reset value.
   assign skip_eff = skip_low_q && riscv_config__i32c;

   // Outputs depend on state registers only (plus mode / reset gating).
   assign bus.instruction__mode = mode;
   assign bus.instruction_valid = inst_valid;
   assign bus.instruction_pc    = inst_valid ? head_pc_q : 32'h0;
   assign bus.fetch_req_address = fetch_pc_q;
   assign bus.fetch_req_valid   = !reset && !outstanding_q && (count_q <= 2'd1);

   always_comb begin
      bus.instruction__data = 32'h0;
      if (inst_valid) begin
         if (is_comp || count_q == 2'd1) begin
            bus.instruction__data = {16'h0, h0};
         end else begin
            bus.instruction__data = {h1, h0};
         end
      end
   end

   always_comb begin
      shamt = 2'd0;
      if (consume) begin
         shamt = one_half ? 2'd1 : 2'd2;
      end
      case (shamt)
         2'd1:    sh_vec = {16'h0, hbuf_q[47:16]};
         2'd2:    sh_vec = {32'h0, hbuf_q[47:32]};
         default: sh_vec = hbuf_q;
      endcase
      cnt_s = count_q - shamt;

      // Shift first, then append the response behind the surviving halfwords.
      app_vec  = skip_eff ? {16'h0, bus.fetch_resp_data[31:16]} : bus.fetch_resp_data;
      app_n    = skip_eff ? 2'd1 : 2'd2;
      keep_vec = (48'h1 << {cnt_s, 4'b0000}) - 48'h1;
      ext_vec  = {16'h0, app_vec} << {cnt_s, 4'b0000};

      hbuf_d        = hbuf_q;
      count_d       = count_q;
      head_pc_d     = head_pc_q;
      fetch_pc_d    = fetch_pc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      skip_low_d    = skip_low_q;

      if (redirect_valid) begin
         count_d    = 2'd0;
         head_pc_d  = redirect_pc & ~32'h1;
         fetch_pc_d = redirect_pc & ~32'h3;
         skip_low_d = redirect_pc[1] & riscv_config__i32c;
         // Any request still in flight (or accepted right now) returns stale data.
         if (fire || (outstanding_q && !resp)) begin
            outstanding_d = 1'b1;
            discard_d     = 1'b1;
         end else begin
            outstanding_d = 1'b0;
            discard_d     = 1'b0;
         end
      end else begin
         hbuf_d    = sh_vec;
         count_d   = cnt_s;
         head_pc_d = head_pc_q + {29'h0, shamt, 1'b0};
         if (fire) begin
            outstanding_d = 1'b1;
            fetch_pc_d    = fetch_pc_q + 32'd4;
         end
         if (resp) begin
            outstanding_d = 1'b0;
            discard_d     = 1'b0;
            if (!discard_q) begin
               hbuf_d     = (sh_vec & keep_vec) | ext_vec;
               count_d    = cnt_s + app_n;
               skip_low_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hbuf_q        <= 48'h0;
         count_q       <= 2'd0;
         head_pc_q     <= RESET_PC;
         fetch_pc_q    <= RESET_PC & ~32'h3;
         outstanding_q <= 1'b0;
         discard_q     <= 1'b0;
         skip_low_q    <= RESET_PC[1];
      end else begin
         hbuf_q        <= hbuf_d;
         count_q       <= count_d;
         head_pc_q     <= head_pc_d;
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         skip_low_q    <= skip_low_d;
      end
   end

`ifdef RISCV_FETCH_ALIGN_FAULT_EN
   // One fault bit per buffered halfword, shifted and appended alongside hbuf.
   logic [2:0] hflt_q, hflt_d, sh_flt, keep_flt;
   logic [1:0] app_flt;
   logic [4:0] ext_flt;

   assign head_fault = hflt_q[0];
   assign bus.instruction_fault = inst_valid && (head_fault || (!one_half && hflt_q[1]));

   always_comb begin
      sh_flt   = hflt_q >> shamt;
      keep_flt = (3'b001 << cnt_s) - 3'b001;
      app_flt  = skip_eff ? {1'b0, bus.fetch_resp_error} : {2{bus.fetch_resp_error}};
      ext_flt  = {3'b000, app_flt} << cnt_s;
      hflt_d   = hflt_q;
      if (!redirect_valid) begin
         hflt_d = sh_flt;
         if (resp && !discard_q) begin
            hflt_d = (sh_flt & keep_flt) | ext_flt[2:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hflt_q <= 3'b000;
      end else begin
         hflt_q <= hflt_d;
      end
   end
`else
   assign head_fault = 1'b0;
`endif

endmodule

// File: doc/riscv_i32c_fetch_align.md
Name: riscv_i32c_fetch_align

Overview:
- Instruction-side producer for the decode stage.
- Issues word-aligned fetch requests and buffers returned 32-bit words as halfwords.
- Presents one aligned instruction per handshake on the instruction__mode / instruction__data interface, including 16-bit compressed instructions and 32-bit instructions that straddle a word boundary.
- Sits between the instruction memory port and the RV32I/RV32E decoders; redirected by branch/trap logic.

Parameters:
- RESET_PC, 32'h0: address of the first instruction after reset; halfword aligned.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous reset, active-high
- riscv_config__i32c  input  1  compressed instructions enabled
- mode  input  3  current privilege mode
- redirect_valid  input  1  flush buffer and restart at redirect_pc
- redirect_pc  input  32  new PC; bit0 ignored
- fetch_req_valid  output  1  fetch request pending
- fetch_req_address  output  32  word-aligned fetch address
- fetch_req_ready  input  1  memory accepts request this cycle
- fetch_resp_valid  input  1  read data returned
- fetch_resp_data  input  32  read data, little-endian
- instruction_valid  output  1  instruction__data holds a complete instruction
- instruction_ready  input  1  consumer accepts instruction this cycle
- instruction__mode  output  3  equals mode (combinational)
- instruction__data  output  32  aligned instruction; compressed forms zero-extended
- instruction_pc  output  32  PC of presented instruction

Behaviour:
- State:
  - halfword buffer h0..h2, with count 0..3 (h0 is the head)
  - head_pc, the PC of h0
  - fetch_pc, word aligned
  - outstanding, discard and skip_low flags
- Reset values:
  - count=0, head_pc=RESET_PC, fetch_pc=RESET_PC&~3
  - outstanding=0, discard=0, skip_low=RESET_PC[1]&riscv_config__i32c
  - all outputs 0 except instruction__mode=mode and fetch_req_address=RESET_PC&~3
- Compressed when riscv_config__i32c=1 and h0[1:0]!=2'b11; otherwise the instruction is 32-bit.
- instruction_valid:
  - compressed: count>=1
  - 32-bit: count>=2
- instruction__data:
  - compressed: {16'h0,h0}
  - 32-bit: {h1,h0}
  - all-zero when instruction_valid=0
- instruction_valid, instruction__data and instruction_pc are driven from registers only; they do not respond combinationally to redirect_valid.
- Request rule:
  - fetch_req_valid = !outstanding && count<=1.
  - fetch_req_address = fetch_pc.
  - On fetch_req_valid&&fetch_req_ready: outstanding=1, fetch_pc+=4.
  - Only one request is outstanding at a time.
  - Response arrives no earlier than the cycle after acceptance.
- Response without discard:
  - Append low then high halfword.
  - If skip_low=1, append only the high halfword and clear skip_low.
  - Clear outstanding.
  - count never exceeds 3.
- Response with discard=1: drop the data; clear outstanding and discard.
- Consume (instruction_valid&&instruction_ready):
  - Shift out 1 (compressed) or 2 halfwords.
  - head_pc += 2 or 4.
  - If a response arrives in the same cycle, shift first, then append.
- Redirect takes priority over consume and response in the same cycle:
  - count=0
  - head_pc=redirect_pc&~1
  - fetch_pc=redirect_pc&~3
  - skip_low=redirect_pc[1]&riscv_config__i32c
- Redirect with outstanding=1 and no response in the same cycle: set discard=1.
- Redirect in the same cycle as a response: drop the response; outstanding=0.
- Redirect while a request is presented but not yet accepted: the address changes on the next cycle. The memory port must tolerate this.
- head_pc and fetch_pc wrap modulo 2^32.

Optional Feature:
- Macro: RISCV_FETCH_ALIGN_FAULT_EN.
- With the macro defined:
  - Adds input fetch_resp_error (1) and output instruction_fault (1).
  - Each buffered halfword carries a fault bit taken from its response.
  - instruction_fault=1 when any halfword of the presented instruction is faulted.
  - A faulted head halfword is presented as a 32-bit instruction with count>=1, so a fault never stalls.
  - Consuming a faulted head halfword removes 1 halfword.
- Without the macro: no such ports; all responses are treated as good.

Test Plan:
- 32-bit fetch: reset with RESET_PC=0, memory returns 32'h00A00093 → request to 0x0; instruction_valid with data 32'h00A00093 and pc 0x0; next request to 0x4.
- Two compressed: i32c=1, word 32'h45014501 → instructions at pc 0x0 and 0x2, each with data 32'h00004501.
- Straddle: words 32'h00934501 at 0x0 and 32'h000000A0 at 0x4 → pc 0x0 presents 32'h00004501; pc 0x2 presents 32'h00A00093 only after the second word is returned.
- Redirect with response pending: redirect_pc=0x102 → stale response is dropped; next request is to 0x100; its low half is skipped; first instruction has pc 0x102.
- Backpressure: instruction_ready=0 for 10 cycles with compressed code → count<=3; at most one extra request issued; outputs stable throughout.
- Fault (macro defined): fetch_resp_error=1 on the word at 0x4 → instruction at 0x4 has instruction_fault=1; instruction at 0x0 has instruction_fault=0.
